// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the upstream fifo into a valid/ready stream.
// A head+skid buffer hides the fifo's one-cycle read latency.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] word_cnt
);

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] skid_nxt;
  logic             pop;
  logic [2:0]       load;

  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;

  // Slots committed after this edge; pop frees one, so m_ready feeds fifo_read.
  assign load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Issue a read only when the word it returns is guaranteed a slot.
  assign fifo_read = rst_n & enable & ~fifo_empty & (load < 3'd2);

  // Buffer update: capture the in-flight word and/or pop the head.
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    skid_nxt = skid;
    case (occ)
      2'd0: begin
        if (inflight) begin
          head_nxt = fifo_data;
          occ_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (inflight && pop) begin
          head_nxt = fifo_data;
        end else if (inflight) begin
          skid_nxt = fifo_data;
          occ_nxt  = 2'd2;
        end else if (pop) begin
          occ_nxt  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_nxt = skid;
          occ_nxt  = 2'd1;
        end
      end
      default: begin
        occ_nxt = 2'd0;
      end
    endcase
  end

  // Buffer, in-flight flag and delivered-word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
      word_cnt <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_read;
      head     <= head_nxt;
      skid     <= skid_nxt;
      if (pop) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream
// against a behavioural fifo and a reference queue.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       m_ready = 1'b0;

  logic        fifo_read;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        fifo_read4;
  logic        m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  word_cnt4;

  always #5 clk = ~clk;

  fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready),
    .word_cnt(word_cnt)
  );

  fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read4), .m_valid(m_valid4),
    .m_data(m_data4), .m_ready(m_ready),
    .word_cnt(word_cnt4)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic [7:0] fq[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int pop_cyc[$];
  int nreads = 0;
  int first_rd = -1;
  int first_vl = -1;
  int stab_err = 0;
  int mm4 = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Upstream fifo model: one-cycle read latency, flag updated per edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_read && !fifo_empty) begin
        fifo_data <= fq.pop_front();
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Mid-cycle observer: pops, reads, hold-stability, twin agreement.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_valid && m_data == prev_data))
        stab_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        pop_cyc.push_back(cyc);
      end
      if (m_valid && first_vl < 0) first_vl = cyc;
      if (fifo_read && !fifo_empty) begin
        nreads++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid !== m_valid4 || m_data !== m_data4 ||
          fifo_read !== fifo_read4)
        mm4++;
    end
  end

  task automatic check(input string tag, input int obs,
                       input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clr();
    got.delete();
    pop_cyc.delete();
    exp_q.delete();
    nreads = 0;
    first_rd = -1;
    first_vl = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    clr();
  endtask

  initial begin : stim
    logic [7:0] basic [5];
    int ok;
    int sz;
    basic[0] = 8'hFF; basic[1] = 8'hAA; basic[2] = 8'hCC;
    basic[3] = 8'h11; basic[4] = 8'h1F;

    // reset state, enable high to show the forced read gate
    enable = 1'b1;
    #1;
    check("rst_valid", int'(m_valid), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_cnt", int'(word_cnt), 0);
    check("rst_read", int'(fifo_read), 0);
    ticks(2);
    rst_n = 1'b1;
    clr();

    // basic transfer
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(basic[i]);
    ticks(12);
    check("basic_n", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check("basic_word", int'(got[i]), int'(basic[i]));
    check("basic_lat", first_vl - first_rd, 2);
    if (pop_cyc.size() == 5)
      check("basic_span", pop_cyc[4] - pop_cyc[0], 4);
    check("basic_cnt", int'(word_cnt), 5);
    check("basic_cnt4", int'(word_cnt4), 5);

    // back-pressure
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    ticks(10);
    check("bp_reads", nreads, 2);
    check("bp_valid", int'(m_valid), 1);
    check("bp_hold", int'(m_data), 'h30);
    m_ready = 1'b1;
    ticks(14);
    check("bp_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("bp_word", int'(got[i]), 'h30 + i);
    if (pop_cyc.size() == 8)
      check("bp_span", pop_cyc[7] - pop_cyc[0], 7);
    check("bp_cnt", int'(word_cnt), 8);

    // empty boundary
    do_reset();
    ticks(6);
    check("emp_reads", nreads, 0);
    check("emp_valid", first_vl, -1);
    push(8'h5A);
    ticks(6);
    check("emp_n", got.size(), 1);
    if (got.size() > 0) check("emp_word", int'(got[0]), 'h5A);
    check("emp_cnt", int'(word_cnt), 1);

    // enable drop with a read in flight
    do_reset();
    push(8'h71); push(8'h72); push(8'h73);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_read) begin
        ok = 1;
        break;
      end
    end
    check("en_rd_seen", ok, 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    ticks(8);
    check("en_reads", nreads, 1);
    check("en_n", got.size(), 1);
    if (got.size() > 0) check("en_word", int'(got[0]), 'h71);
    enable = 1'b1;
    ticks(8);
    check("en_n_all", got.size(), 3);
    if (got.size() == 3) begin
      check("en_word1", int'(got[1]), 'h72);
      check("en_word2", int'(got[2]), 'h73);
    end

    // reset mid-stream with both slots full
    do_reset();
    push(8'h01); push(8'h02); push(8'h03);
    ticks(8);
    check("mr_cnt_pre", int'(word_cnt), 3);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    ticks(6);
    check("mr_valid_pre", int'(m_valid), 1);
    check("mr_data_pre", int'(m_data), 'h41);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", int'(m_valid), 0);
    check("mr_data", int'(m_data), 0);
    check("mr_cnt", int'(word_cnt), 0);
    check("mr_read", int'(fifo_read), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    m_ready = 1'b1;
    ticks(6);
    check("mr_quiet_v", first_vl, -1);
    check("mr_quiet_r", nreads, 0);
    push(8'h99);
    ticks(6);
    check("mr_n", got.size(), 1);
    if (got.size() > 0) check("mr_word", int'(got[0]), 'h99);

    // counter wrap on the 4-bit twin
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i * 3));
    ticks(25);
    check("wrap_n", got.size(), 17);
    check("wrap_cnt4", int'(word_cnt4), 1);
    check("wrap_cnt16", int'(word_cnt), 17);

    // random enable/ready/push run against the reference queue
    clr();
    for (int i = 0; i < 300; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      tick();
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    ticks(200);
    sz = exp_q.size();
    check("rnd_n", got.size(), sz);
    for (int i = 0; i < sz && i < got.size(); i++)
      check("rnd_word", int'(got[i]), int'(exp_q[i]));
    check("rnd_cnt16", int'(word_cnt), (17 + sz) % 65536);
    check("rnd_cnt4", int'(word_cnt4), (17 + sz) % 16);
    check("hold_stable", stab_err, 0);
    check("twin_agree", mm4, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
